fp_mult_arbiter: RTL and testbench
==================================

// Module: fp_mult_arbiter
// PURPOSE
// - Shares one multi-cycle FP32 multiplier core between two requesters.
// - Round-robin arbitration; latches the operands and sequences the core with a start/done handshake.
// - Special operands (zero/Inf/NaN) take a fast path and never start the core.
// - Returns the result to the granted requester; a watchdog guards against a hung core.
// PARAMETERS
// - TIMEOUT   64   max cycles in WAIT for core_done before abort (>=2)
// - CNT_W     7    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT
// PORTS
// - clk          in   1   rising-edge clock
// - rst          in   1   asynchronous, active-high reset
// - req_valid    in   2   bit i: requester i presents an operand pair
// - req_ready    out  2   bit i: operands accepted this cycle (one-hot or zero)
// - req_a        in   64  {a1,a0}, FP32 operand A per requester
// - req_b        in   64  {b1,b0}, FP32 operand B per requester
// - resp_valid   out  2   one-hot: result for requester i on resp_result
// - resp_ready   in   2   bit i: requester i takes the result
// - resp_result  out  32  FP32 product
// - resp_err     out  1   qualifies resp_result: watchdog abort
// - core_start   out  1   single-cycle pulse, launches core on core_a/core_b
// - core_a       out  32  latched operand A, stable from start until done
// - core_b       out  32  latched operand B
// - core_done    in   1   single-cycle pulse, core_result valid
// - core_result  in   32  raw core product (normal operands only)
// BEHAVIOUR
// - Reset values: all outputs 0; state=IDLE; rr_ptr=0 (requester 0 favoured first); watchdog=0.
// - FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: if any req_valid, grant g.
//   - g = the requester at rr_ptr if it is valid, else the other one.
//   - Assert req_ready[g] for one cycle; latch a, b and g; rr_ptr <= ~g.
//   - Next state is RESP if either operand is special (result computed into the result register), else ISSUE.
// - ISSUE: core_start=1 for exactly one cycle; clear watchdog; next state WAIT.
// - WAIT: increment watchdog each cycle.
//   - On core_done: result <= core_result, err <= 0, next state RESP.
//   - If watchdog reaches TIMEOUT before core_done: result <= 32'h7FFFFFFF, err <= 1, next state RESP.
//   - A core_done arriving in any state other than WAIT is ignored.
// - RESP: resp_valid[g]=1 and resp_result/resp_err held stable until resp_ready[g]; then IDLE.
//   - resp_ready of the non-granted requester is ignored.
// - Throughput: one operation in flight; req_ready is never asserted outside IDLE.
//   - Minimum normal-path latency: accept -> ISSUE -> WAIT(core) -> RESP.
//   - Fast path: response one cycle after accept.
// - Special classification per operand (e = bits[30:23], m = bits[22:0]):
//   - zero: e==0 (denormals flushed).
//   - inf:  e==FF and m==0.
//   - nan:  e==FF and m!=0.
// - Fast-path result, checked in order, s = a[31]^b[31]:
//   - any NaN -> 32'h7FFFFFFF.
//   - zero x Inf -> 32'h7FFFFFFF.
//   - any zero -> 32'h00000000 (unsigned).
//   - any Inf -> {s, 31'h7F800000}.
// - Simultaneous req_valid on both bits: only g is accepted; the other stays pending and wins next IDLE.
// - Requester i dropping req_valid while waiting is legal; nothing is latched for it.
// - Reset asserted mid-operation: immediately IDLE, outputs 0, in-flight op discarded.
//   - A late core_done after reset is ignored (state is not WAIT).
// STRUCTURE
// - Shared package/header: FP32 constants QNAN=32'h7FFFFFFF, INF_MAG=31'h7F800000, ZERO=32'h0; FSM state encodings.
// - Sub-module: checkspecial (flagZero/flagInf/flagNaN), instantiated twice on the latched operands.
// - Everything else (FSM, round-robin pointer, watchdog, result register) lives in this module.
// TESTING
// - Single op: req0 a=3F800000 b=40000000; core returns 40000000 after 5 cycles
//   -> one core_start; resp_valid=01, result=40000000, err=0.
// - Contention: both valid every cycle after reset
//   -> grants alternate 0,1,0,1; each core_start pairs with its own operands.
// - Fast path: a=00000000 b=7F800000 -> no core_start, result=7FFFFFFF next cycle;
//   a=FF800000 b=3F800000 -> FF800000; a=80000000 b=40400000 -> 00000000.
// - Watchdog: TIMEOUT=8, core_done never pulses -> resp after 8 WAIT cycles, result=7FFFFFFF, err=1.
// - Backpressure: resp_ready[g] held low 10 cycles -> resp_valid/result stable throughout;
//   req_ready stays 00; a stray core_done is ignored.
// - Reset in WAIT: assert rst, then release; late core_done
//   -> no resp_valid, next request handled normally with rr_ptr=0.

Source files
------------

// File: rtl/fp_mult_arbiter_pkg.sv
// Shared constants, FSM encoding and fast-path helpers for the two-requester FP32 multiplier arbiter.
package fp_mult_arbiter_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam int unsigned N_REQ = 2;

    localparam logic [FP_W-1:0] QNAN    = 32'h7FFF_FFFF;
    localparam logic [FP_W-2:0] INF_MAG = 31'h7F80_0000;
    localparam logic [FP_W-1:0] ZERO    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

    // Product of two operands when at least one is zero/Inf/NaN.
    function automatic logic [FP_W-1:0] fast_result(input fp_class_t ca, input fp_class_t cb,
                                                    input logic sign);
        if (ca.nan || cb.nan) begin
            fast_result = QNAN;
        end else if ((ca.zero && cb.inf) || (cb.zero && ca.inf)) begin
            fast_result = QNAN;
        end else if (ca.zero || cb.zero) begin
            fast_result = ZERO;
        end else begin
            fast_result = {sign, INF_MAG};
        end
    endfunction

    function automatic logic [N_REQ-1:0] gnt_onehot(input logic g);
        gnt_onehot = g ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fp_mult_arbiter_checkspecial.sv
// Classifies one FP32 operand as zero (denormals flushed), infinity or NaN.
module fp_mult_arbiter_checkspecial
    import fp_mult_arbiter_pkg::*;
(
    input  logic [FP_W-1:0] op_i,
    output logic            zero_c_o,
    output logic            inf_c_o,
    output logic            nan_c_o
);

    logic [EXP_W-1:0] exp_c;
    logic [MAN_W-1:0] man_c;

    assign exp_c    = op_i[FP_W-2:MAN_W];
    assign man_c    = op_i[MAN_W-1:0];
    assign zero_c_o = (exp_c == '0);
    assign inf_c_o  = (exp_c == '1) && (man_c == '0);
    assign nan_c_o  = (exp_c == '1) && (man_c != '0);

endmodule

// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP32 multiplier core between two requesters,
// with a special-operand fast path and a watchdog on the core handshake.
module fp_mult_arbiter
    import fp_mult_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  logic [N_REQ*FP_W-1:0] req_a_i,
    input  logic [N_REQ*FP_W-1:0] req_b_i,
    output logic [N_REQ-1:0]      resp_valid_o,
    input  logic [N_REQ-1:0]      resp_ready_i,
    output logic [FP_W-1:0]       resp_result_o,
    output logic                  resp_err_o,
    output logic                  core_start_o,
    output logic [FP_W-1:0]       core_a_o,
    output logic [FP_W-1:0]       core_b_o,
    input  logic                  core_done_i,
    input  logic [FP_W-1:0]       core_result_i
);

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             gnt_q, gnt_d, gnt_c;
    logic [FP_W-1:0]  a_q, a_d, b_q, b_d;
    logic [FP_W-1:0]  result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             core_start_q;
    logic [N_REQ-1:0] resp_valid_q;
    logic [N_REQ-1:0] req_ready_c;
    logic [FP_W-1:0]  sel_a_c, sel_b_c;
    logic             za_c, ia_c, na_c, zb_c, ib_c, nb_c;
    fp_class_t        cls_a_c, cls_b_c;
    logic             special_c;

    // Winner: the favoured requester if it is asking, otherwise the other one.
    assign gnt_c   = req_valid_i[rr_q] ? rr_q : ~rr_q;
    assign sel_a_c = gnt_c ? req_a_i[2*FP_W-1:FP_W] : req_a_i[FP_W-1:0];
    assign sel_b_c = gnt_c ? req_b_i[2*FP_W-1:FP_W] : req_b_i[FP_W-1:0];

    // Classified on the operands being latched so the fast path answers the next cycle.
    fp_mult_arbiter_checkspecial u_chk_a (
        .op_i     (sel_a_c),
        .zero_c_o (za_c),
        .inf_c_o  (ia_c),
        .nan_c_o  (na_c)
    );

    fp_mult_arbiter_checkspecial u_chk_b (
        .op_i     (sel_b_c),
        .zero_c_o (zb_c),
        .inf_c_o  (ib_c),
        .nan_c_o  (nb_c)
    );

    assign cls_a_c   = '{zero: za_c, inf: ia_c, nan: na_c};
    assign cls_b_c   = '{zero: zb_c, inf: ib_c, nan: nb_c};
    assign special_c = |{za_c, ia_c, na_c, zb_c, ib_c, nb_c};

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        err_d       = err_q;
        wd_d        = wd_q;
        req_ready_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    req_ready_c = gnt_onehot(gnt_c);
                    gnt_d       = gnt_c;
                    rr_d        = ~gnt_c;
                    a_d         = sel_a_c;
                    b_d         = sel_b_c;
                    if (special_c) begin
                        result_d = fast_result(cls_a_c, cls_b_c, sel_a_c[FP_W-1] ^ sel_b_c[FP_W-1]);
                        err_d    = 1'b0;
                        state_d  = ST_RESP;
                    end else begin
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A done on the last permitted cycle still wins over the abort.
                if (core_done_i) begin
                    result_d = core_result_i;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (wd_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = QNAN;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    wd_d     = wd_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready_i[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            wd_q         <= '0;
            core_start_q <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            err_q        <= err_d;
            wd_q         <= wd_d;
            core_start_q <= (state_d == ST_ISSUE);
            resp_valid_q <= (state_d == ST_RESP) ? gnt_onehot(gnt_d) : '0;
        end
    end

    assign req_ready_o   = req_ready_c;
    assign resp_valid_o  = resp_valid_q;
    assign resp_result_o = result_q;
    assign resp_err_o    = err_q;
    assign core_start_o  = core_start_q;
    assign core_a_o      = a_q;
    assign core_b_o      = b_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Randomized self-checking bench for fp_mult_arbiter against a transaction-level reference model.
module tb_fp_mult_arbiter;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam logic [31:0] TB_QNAN    = 32'h7FFF_FFFF;
    localparam int          BIG        = 32'h3FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0, req_ready, resp_valid, resp_ready = '0;
    logic [63:0] req_a = '0, req_b = '0;
    logic [31:0] resp_result, core_a, core_b, core_result = '0;
    logic        resp_err, core_start, core_done = 1'b0;

    fp_mult_arbiter #(.TIMEOUT(TB_TIMEOUT), .CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_result_o(resp_result),
        .resp_err_o   (resp_err),
        .core_start_o (core_start),
        .core_a_o     (core_a),
        .core_b_o     (core_b),
        .core_done_i  (core_done),
        .core_result_i(core_result)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Pending operand pairs per requester
    logic [31:0] qa0[$], qb0[$], qa1[$], qb1[$];

    // Knobs
    int unsigned hang_pct = 0, ready_pct = 100, stray_pct = 0, drop_pct = 0, lat_fix = 0;
    bit          val_fix_en = 0;
    logic [31:0] val_fix = '0;
    bit          force_stray = 0;

    // Transaction-level model
    int          cyc = 0;
    bit          busy = 0, fast = 0, exp_g = 0, favour = 0, exp_err = 0;
    logic [31:0] ea = '0, eb = '0, exp_res = '0;
    int          acc_cyc = -10, resp_cyc = BIG;
    bit          core_pend = 0, hang = 0;
    int          done_cyc = 0;
    logic [31:0] done_val = '0;

    // Observations
    int          n_start_obs = 0, last_start_cyc = 0, first_rv_cyc = 0;
    bit          rv_seen = 0;
    int          grants[$];
    logic [31:0] resp_log[$];
    logic        last_err = 0;
    logic [1:0]  last_rv = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] x);
        int unsigned e = (x >> 23) & 32'hFF;
        return (e == 0) || (e == 255);
    endfunction

    function automatic logic [31:0] ref_fast(input logic [31:0] a, input logic [31:0] b);
        int unsigned ea_l = (a >> 23) & 32'hFF;
        int unsigned eb_l = (b >> 23) & 32'hFF;
        int unsigned ma   = a & 32'h007F_FFFF;
        int unsigned mb   = b & 32'h007F_FFFF;
        bit za = (ea_l == 0), zb = (eb_l == 0);
        bit ia = (ea_l == 255) && (ma == 0), ib = (eb_l == 255) && (mb == 0);
        bit na = (ea_l == 255) && (ma != 0), nb = (eb_l == 255) && (mb != 0);
        if (na || nb) return TB_QNAN;
        if ((za && ib) || (zb && ia)) return TB_QNAN;
        if (za || zb) return 32'h0;
        return ((a ^ b) & 32'h8000_0000) | 32'h7F80_0000;
    endfunction

    function automatic logic [31:0] rnd_normal();
        return {1'($urandom_range(1, 0)), 8'($urandom_range(254, 1)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rnd_op();
        int unsigned r = $urandom_range(9, 0);
        logic [22:0] m = 23'($urandom);
        if (r == 0) return {1'($urandom_range(1, 0)), 8'h00, m};
        if (r == 1) return {1'($urandom_range(1, 0)), 8'hFF, 23'h0};
        if (r == 2) return {1'($urandom_range(1, 0)), 8'hFF, m | 23'h1};
        return rnd_normal();
    endfunction

    // One clock: check registered outputs, drive inputs, check the handshake, advance the model.
    task automatic step();
        logic [1:0]  exp_rv, exp_rr, v;
        logic [31:0] oa0, ob0, oa1, ob1;
        bit          exp_start, g;
        @(negedge clk);
        cyc++;
        n_start_obs += int'(core_start);
        if (core_start) last_start_cyc = cyc;
        if (resp_valid != 2'b00 && !rv_seen) begin
            rv_seen      = 1;
            first_rv_cyc = cyc;
        end
        exp_start = busy && !fast && (cyc == acc_cyc + 1);
        chk("core_start", 32'(core_start), 32'(exp_start));
        if (exp_start) begin
            chk("core_a", core_a, ea);
            chk("core_b", core_b, eb);
            core_pend = 1;
            hang = ($urandom_range(99, 0) < hang_pct);
            if (hang) begin
                resp_cyc = cyc + 1 + int'(TB_TIMEOUT);
                exp_res  = TB_QNAN;
                exp_err  = 1;
            end else begin
                done_cyc = cyc + ((lat_fix != 0) ? int'(lat_fix) : int'($urandom_range(6, 1)));
                done_val = val_fix_en ? val_fix : $urandom;
                resp_cyc = done_cyc + 1;
                exp_res  = done_val;
                exp_err  = 0;
            end
        end
        exp_rv = (busy && cyc >= resp_cyc) ? (exp_g ? 2'b10 : 2'b01) : 2'b00;
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_rv != 2'b00) begin
            chk("resp_result", resp_result, exp_res);
            chk("resp_err", 32'(resp_err), 32'(exp_err));
        end

        core_done   = 1'b0;
        core_result = $urandom;
        if (core_pend && !hang && cyc == done_cyc) begin
            core_done   = 1'b1;
            core_result = done_val;
            core_pend   = 0;
        end else if (!core_pend && (force_stray || $urandom_range(99, 0) < stray_pct)) begin
            core_done   = 1'b1;
            force_stray = 0;
        end
        resp_ready[0] = ($urandom_range(99, 0) < ready_pct);
        resp_ready[1] = ($urandom_range(99, 0) < ready_pct);
        oa0 = (qa0.size() != 0) ? qa0[0] : $urandom;
        ob0 = (qb0.size() != 0) ? qb0[0] : $urandom;
        oa1 = (qa1.size() != 0) ? qa1[0] : $urandom;
        ob1 = (qb1.size() != 0) ? qb1[0] : $urandom;
        v[0] = (qa0.size() != 0) && ($urandom_range(99, 0) >= drop_pct);
        v[1] = (qa1.size() != 0) && ($urandom_range(99, 0) >= drop_pct);
        req_valid = v;
        req_a     = {oa1, oa0};
        req_b     = {ob1, ob0};
        #1;
        g      = v[favour] ? favour : !favour;
        exp_rr = (!busy && v != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));

        if (exp_rv != 2'b00 && resp_ready[exp_g]) begin
            busy      = 0;
            core_pend = 0;
            last_err  = resp_err;
            last_rv   = resp_valid;
            resp_log.push_back(resp_result);
        end else if (exp_rr != 2'b00) begin
            ea = g ? oa1 : oa0;
            eb = g ? ob1 : ob0;
            if (g) begin
                void'(qa1.pop_front());
                void'(qb1.pop_front());
            end else begin
                void'(qa0.pop_front());
                void'(qb0.pop_front());
            end
            busy    = 1;
            exp_g   = g;
            favour  = !g;
            acc_cyc = cyc;
            rv_seen = 0;
            grants.push_back(int'(g));
            fast = is_special(ea) || is_special(eb);
            if (fast) begin
                resp_cyc = cyc + 1;
                exp_res  = ref_fast(ea, eb);
                exp_err  = 0;
            end else begin
                resp_cyc = BIG;
            end
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while ((busy || qa0.size() != 0 || qa1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain", 32'(int'(busy) + qa0.size() + qa1.size()), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        core_done  = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_core_start", 32'(core_start), 32'h0);
        chk("rst_core_a", core_a, 32'h0);
        chk("rst_core_b", core_b, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        busy      = 0;
        favour    = 0;
        core_pend = 0;
        acc_cyc   = -10;
        resp_cyc  = BIG;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    initial begin
        int s0, k;
        logic [31:0] held;
        do_reset();

        // Contention right after reset: grants alternate starting with requester 0
        for (int i = 0; i < 4; i++) begin
            qa0.push_back(rnd_normal()); qb0.push_back(rnd_normal());
            qa1.push_back(rnd_normal()); qb1.push_back(rnd_normal());
        end
        grants.delete();
        run_idle(200);
        chk("rr_count", 32'(grants.size()), 32'd8);
        foreach (grants[i]) chk("rr_grant", 32'(grants[i]), 32'(i % 2));

        // Single normal op with a 5-cycle core
        lat_fix = 5; val_fix_en = 1; val_fix = 32'h4000_0000;
        s0 = n_start_obs; resp_log.delete();
        qa0.push_back(32'h3F80_0000); qb0.push_back(32'h4000_0000);
        run_idle(50);
        chk("single_starts", 32'(n_start_obs - s0), 32'd1);
        chk("single_result", (resp_log.size() != 0) ? resp_log[0] : 32'hDEAD_BEEF, 32'h4000_0000);
        chk("single_err", 32'(last_err), 32'h0);
        chk("single_rv", 32'(last_rv), 32'h1);
        chk("single_lat", 32'(first_rv_cyc - last_start_cyc), 32'd6);
        lat_fix = 0; val_fix_en = 0;

        // Fast path: no core activity
        s0 = n_start_obs; resp_log.delete();
        qa0.push_back(32'h0000_0000); qb0.push_back(32'h7F80_0000);
        qa0.push_back(32'hFF80_0000); qb0.push_back(32'h3F80_0000);
        qa0.push_back(32'h8000_0000); qb0.push_back(32'h4040_0000);
        run_idle(50);
        chk("fast_starts", 32'(n_start_obs - s0), 32'd0);
        chk("fast_n", 32'(resp_log.size()), 32'd3);
        if (resp_log.size() == 3) begin
            chk("fast_zero_inf", resp_log[0], 32'h7FFF_FFFF);
            chk("fast_neg_inf", resp_log[1], 32'hFF80_0000);
            chk("fast_neg_zero", resp_log[2], 32'h0000_0000);
        end

        // Watchdog: core never answers
        hang_pct = 100;
        qa0.push_back(32'h3FC0_0000); qb0.push_back(32'h4020_0000);
        run_idle(50);
        chk("wd_result", resp_log[$], 32'h7FFF_FFFF);
        chk("wd_err", 32'(last_err), 32'h1);
        chk("wd_lat", 32'(first_rv_cyc - last_start_cyc), 32'(TB_TIMEOUT + 1));
        hang_pct = 0;

        // Backpressure with stray core_done pulses and a competing request
        lat_fix = 2; ready_pct = 0; stray_pct = 100;
        qa0.push_back(rnd_normal()); qb0.push_back(rnd_normal());
        qa1.push_back(rnd_normal()); qb1.push_back(rnd_normal());
        k = 0;
        while (!(busy && rv_seen) && k < 50) begin step(); k++; end
        chk("bp_reached", 32'(rv_seen), 32'h1);
        held = resp_result;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold", resp_result, held);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
        end
        lat_fix = 0; ready_pct = 100; stray_pct = 0;
        run_idle(100);

        // Reset while the core is busy, then a late core_done
        hang_pct = 100;
        qa0.push_back(rnd_normal()); qb0.push_back(rnd_normal());
        k = 0;
        while (!(core_pend && cyc >= last_start_cyc + 3) && k < 50) begin step(); k++; end
        chk("wait_reached", 32'(core_pend), 32'h1);
        do_reset();
        hang_pct = 0;
        force_stray = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("late_done_rv", 32'(resp_valid), 32'h0);
        end
        grants.delete();
        qa0.push_back(rnd_normal()); qb0.push_back(rnd_normal());
        qa1.push_back(rnd_normal()); qb1.push_back(rnd_normal());
        run_idle(100);
        chk("post_rst_grant", (grants.size() != 0) ? 32'(grants[0]) : 32'hF, 32'h0);

        // Random traffic
        hang_pct = 10; ready_pct = 60; stray_pct = 20; drop_pct = 20;
        for (int i = 0; i < 120; i++) begin
            qa0.push_back(rnd_op()); qb0.push_back(rnd_op());
            qa1.push_back(rnd_op()); qb1.push_back(rnd_op());
        end
        run_idle(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
